// File: rtl/jk_count_sequencer.sv
// jk_count_sequencer: sequences an external bank of WIDTH JK cells as a
// loadable up/down counter. One command at a time is accepted over a
// valid/ready handshake. Per-bit J/K drive is derived from the bank's fed-back
// Q, and completion is signalled with a one-cycle done pulse.
module jk_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_UP    = 2'b01,
      OP_DOWN  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   state_e           state_q;
   op_e              op_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] rem_q;
   logic             busy_q;
   logic             done_q;

   logic             accept;
   logic             zero_step;
   logic [WIDTH-1:0] toggle_d;
   logic [WIDTH-1:0] j_d;
   logic [WIDTH-1:0] k_d;

   // Ready only in IDLE. It is gated by clr so that it drops at once, without
   // waiting for the asynchronous reset to reach the state register.
   assign cmd_ready = (state_q == ST_IDLE) && !clr;
   assign accept    = cmd_valid && cmd_ready;

   // A count command with zero steps skips RUN and goes straight to DONE.
   assign zero_step = ((op_e'(cmd_op) == OP_UP) || (op_e'(cmd_op) == OP_DOWN))
                      && (cmd_data == '0);

   // Control FSM with registered busy/done flags.
   // NOTE: sequential state uses non-blocking (<=) assignments so that every
   // register samples pre-edge values; blocking assignments here would create
   // order-dependent simulation and mismatch the synthesized flops.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_q   <= op_e'(cmd_op);
                  data_q <= cmd_data;
                  rem_q  <= cmd_data;
                  if (zero_step) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if ((op_q == OP_UP) || (op_q == OP_DOWN)) begin
                  rem_q <= rem_q - WIDTH'(1);
                  if (rem_q == WIDTH'(1)) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Toggle mask: bit i toggles when all lower bits are ones (up) or zeros (down).
   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      toggle_d    = '0;
      toggle_d[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         if (op_q == OP_DOWN) begin
            toggle_d[i] = toggle_d[i-1] & ~q[i-1];
         end else begin
            toggle_d[i] = toggle_d[i-1] & q[i-1];
         end
      end
   end

   // J/K drive: hold (0/0) outside RUN, otherwise set by the latched op.
   always_comb begin
      j_d = '0;
      k_d = '0;
      if (state_q == ST_RUN) begin
         case (op_q)
            OP_LOAD: begin
               j_d = data_q;
               k_d = ~data_q;
            end
            OP_CLEAR: begin
               k_d = '1;
            end
            default: begin
               j_d = toggle_d;
               k_d = toggle_d;
            end
         endcase
      end
   end

   assign j    = j_d;
   assign k    = k_d;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Testbench for jk_count_sequencer: models the JK cell bank, then checks the
// DUT every cycle against a queue of expected per-cycle outputs. The queue is
// built from the counter's arithmetic meaning: each step is value +/- 1, and
// the toggle mask is the xor of consecutive values.
module tb_jk_count_sequencer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clr;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic [W-1:0] q;
   logic [W-1:0] j;
   logic [W-1:0] k;
   logic         busy;
   logic         done;

   logic [W-1:0] bank;
   logic         preload_en;
   logic [W-1:0] preload_val;

   typedef struct {
      logic         ready;
      logic         busy;
      logic         done;
      logic [W-1:0] j;
      logic [W-1:0] k;
      logic [W-1:0] qv;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] m_val;
   bit           chk_en;
   int           checks;
   int           errors;

   jk_count_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .q         (q),
      .j         (j),
      .k         (k),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // JK cell bank clocked on the same edge as the DUT; the preload port lets
   // the bench place the bank at a chosen starting value.
   always @(posedge clk) begin
      if (preload_en) bank <= preload_val;
      else            bank <= (j & ~bank) | (~k & bank);
   end
   assign q = bank;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic r, input logic b, input logic d,
                               input logic [W-1:0] jj, input logic [W-1:0] kk,
                               input logic [W-1:0] qq);
      exp_t e;
      e.ready = r; e.busy = b; e.done = d; e.j = jj; e.k = kk; e.qv = qq;
      return e;
   endfunction

   // Expected cycle sequence for one command, starting at the acceptance edge.
   function automatic void push_cmd(input logic [1:0] op, input logic [W-1:0] data);
      logic [W-1:0] cur;
      logic [W-1:0] nxt;
      cur = m_val;
      case (op)
         2'b00: begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, data, ~data, cur));
            cur = data;
         end
         2'b11: begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '1, cur));
            cur = '0;
         end
         default: begin
            for (int s = 0; s < int'(data); s++) begin
               nxt = (op == 2'b01) ? cur + W'(1) : cur - W'(1);
               exp_q.push_back(mk(1'b0, 1'b1, 1'b0, cur ^ nxt, cur ^ nxt, cur));
               cur = nxt;
            end
         end
      endcase
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, '0, '0, cur));
      m_val = cur;
   endfunction

   // Per-cycle compare against the model; an empty queue means idle/holding.
   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = mk(1'b1, 1'b0, 1'b0, '0, '0, m_val);
         check("cyc_ready", 32'(cmd_ready), 32'(e.ready));
         check("cyc_busy",  32'(busy),      32'(e.busy));
         check("cyc_done",  32'(done),      32'(e.done));
         check("cyc_j",     32'(j),         32'(e.j));
         check("cyc_k",     32'(k),         32'(e.k));
         check("cyc_q",     32'(q),         32'(e.qv));
      end
   end

   task automatic preload(input logic [W-1:0] v);
      preload_val = v;
      preload_en  = 1'b1;
      @(posedge clk); #1;
      preload_en  = 1'b0;
      m_val       = v;
   endtask

   task automatic issue(input logic [1:0] op, input logic [W-1:0] data);
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
      cmd_op    = 2'($urandom);
      push_cmd(op, data);
   endtask

   task automatic finish_cmd();
      int n;
      n = exp_q.size();
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]   rop;
      logic [W-1:0] rdata;
      checks      = 0;
      errors      = 0;
      chk_en      = 1'b0;
      clr         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_data    = '0;
      preload_en  = 1'b1;
      preload_val = '0;
      m_val       = '0;

      // Reset state
      repeat (2) @(posedge clk); #1;
      preload_en = 1'b0;
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_j",     32'(j),         32'd0);
      check("rst_k",     32'(k),         32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      clr = 1'b0;
      #1;
      check("rel_ready", 32'(cmd_ready), 32'd1);
      chk_en = 1'b1;
      @(posedge clk); #1;

      // Load 0xA over 0x3
      preload(4'h3);
      issue(2'b00, 4'hA);
      check("load_j", 32'(j), 32'hA);
      check("load_k", 32'(k), 32'h5);
      finish_cmd();
      check("load_q", 32'(q), 32'hA);

      // Up with wrap: 0xE + 3
      preload(4'hE);
      issue(2'b01, 4'd3);
      check("up_q0", 32'(q), 32'hE);
      @(posedge clk); #1; check("up_q1", 32'(q), 32'hF);
      @(posedge clk); #1; check("up_q2", 32'(q), 32'h0);
      @(posedge clk); #1; check("up_q3", 32'(q), 32'h1);
      check("up_done", 32'(done), 32'd1);
      @(posedge clk); #1;

      // Down with wrap: 0x1 - 2, second mask all ones
      preload(4'h1);
      issue(2'b10, 4'd2);
      @(posedge clk); #1;
      check("dn_q1",   32'(q), 32'h0);
      check("dn_mask", 32'(j), 32'hF);
      @(posedge clk); #1;
      check("dn_q2",   32'(q), 32'hF);
      @(posedge clk); #1;

      // Zero-step up: straight to done, no toggling
      issue(2'b01, 4'd0);
      check("z_done", 32'(done), 32'd1);
      check("z_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("z_q", 32'(q), 32'hF);

      // Clear with a second command held valid through RUN and DONE
      preload(4'h7);
      cmd_op = 2'b11; cmd_data = 4'h9; cmd_valid = 1'b1;
      @(posedge clk); #1;
      push_cmd(2'b11, 4'h9);
      cmd_op = 2'b00; cmd_data = 4'h5;
      check("hold_ready_run", 32'(cmd_ready), 32'd0);
      repeat (2) @(posedge clk); #1;
      check("clr_q",          32'(q),         32'h0);
      check("hold_busy",      32'(busy),      32'd0);
      check("hold_ready_idl", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      push_cmd(2'b00, 4'h5);
      check("held_accept_busy", 32'(busy), 32'd1);
      finish_cmd();
      check("held_q", 32'(q), 32'h5);

      // Reset mid-run: up 10 from 0, clr after 4 steps
      preload(4'h0);
      issue(2'b01, 4'd10);
      repeat (4) @(posedge clk); #1;
      chk_en = 1'b0;
      check("mid_q", 32'(q), 32'h4);
      clr = 1'b1;
      #1;
      check("mid_j",     32'(j),         32'd0);
      check("mid_k",     32'(k),         32'd0);
      check("mid_busy",  32'(busy),      32'd0);
      check("mid_done",  32'(done),      32'd0);
      check("mid_ready", 32'(cmd_ready), 32'd0);
      exp_q.delete();
      m_val = 4'h4;
      @(posedge clk); #1;
      check("mid_hold_q", 32'(q),    32'h4);
      check("mid_done2",  32'(done), 32'd0);
      clr = 1'b0;
      #1;
      check("mid_rel_ready", 32'(cmd_ready), 32'd1);
      chk_en = 1'b1;
      issue(2'b10, 4'd3);
      finish_cmd();
      check("mid_after_q", 32'(q), 32'h1);

      // Randomized commands checked by the per-cycle model
      repeat (30) begin
         if ($urandom_range(0, 3) == 0) preload(W'($urandom));
         rop   = 2'($urandom_range(0, 3));
         rdata = W'($urandom);
         issue(rop, rdata);
         finish_cmd();
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_count_sequencer.md
# jk_count_sequencer

Command-driven controller that sequences a bank of WIDTH external JK flip-flop cells as a loadable up/down counter. It accepts one command at a time over a valid/ready handshake and computes per-bit J/K drive from the bank's fed-back Q. It reports completion with a one-cycle done pulse. It sits between control logic and the JK cell bank; the bank shares this block's clock.

## Interface
Parameters:
- WIDTH, 4: number of JK cells driven; also the width of the step count.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 load, 01 count up, 10 count down, 11 clear.
- cmd_data  input  WIDTH  load value (op 00) or step count (ops 01/10); ignored for op 11.
- q  input  WIDTH  current Q of the JK cell bank.
- j  output  WIDTH  J drive to the cells.
- k  output  WIDTH  K drive to the cells.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- Registered state: FSM state, op_r (2 bits), data_r (WIDTH bits), remaining-steps counter rem (WIDTH bits).
- IDLE:
  - cmd_ready=1; j=k=0, so the cells hold.
  - Acceptance is cmd_valid & cmd_ready. On acceptance, latch op_r, data_r and rem=cmd_data.
  - If the accepted op is up or down with cmd_data=0, go to DONE. Otherwise go to RUN.
- RUN, j/k are combinational from op_r, data_r and q:
  - Load: j=data_r, k=~data_r. Go to DONE next edge.
  - Clear: j=0, k=all ones. Go to DONE next edge.
  - Up: toggle mask t[0]=1, t[i]=&q[i-1:0]. Drive j=k=t. rem decrements each edge. Go to DONE on the edge where rem==1.
  - Down: t[0]=1, t[i]=&~q[i-1:0]. Drive j=k=t. Exit rule is the same as Up.
- DONE: done=1, cmd_ready=0, j=k=0. Go to IDLE next edge.
- Arithmetic:
  - Counting is modulo 2^WIDTH. Wrap-around (all ones up to 0, 0 down to all ones) needs no special casing.
  - Maximum steps per command is 2^WIDTH-1.
- cmd_valid while not in IDLE is ignored. The command is not queued, and the requester must hold cmd_valid until it is accepted.
- cmd_op, cmd_data and q are sampled or used only as described above. Changes to cmd_op or cmd_data after acceptance have no effect.
- clr asserted at any time forces the following immediately, without waiting for a clock:
  - state=IDLE, rem=0, op_r=00, data_r=0;
  - j=k=0, busy=0, done=0.
  - The cell bank's own reset is handled outside this block. This block only guarantees hold drive during and after clr.
- cmd_ready is 0 while clr is high. It returns to 1 when clr deasserts.

## Timing
- Reset values: cmd_ready=0 during clr and 1 after; j=0, k=0, busy=0, done=0.
- Command accepted at edge E0.
- For load or clear:
  - Drive occurs in cycle E0–E1, and the cells update at E1.
  - done is high in cycle E1–E2; cmd_ready is 1 again after E2.
- For up/down with N>0 steps:
  - A drive cycle occurs in each of the N cycles after E0. Cell q reaches its final value at edge E_N.
  - done is high in cycle E_N–E_{N+1}; the next command can be accepted at E_{N+2}.
- For up/down with N=0: done is high in cycle E0–E1, and the cells never toggle.
- busy=1 exactly during RUN cycles. busy and done are never high together.
- j/k are valid combinationally from q within the same cycle. The cells must be clocked by clk on the same edge as this FSM.

## Test plan
- Reset: assert clr mid-cycle with no clock edge. Outputs go to j=k=0, busy=0, done=0 immediately. After release, cmd_ready=1 and no cell changes.
- Load: op 00, data 0xA, with the bank at 0x3.
  - During the single RUN cycle, j=0xA and k=0x5.
  - q=0xA after E1; done is high for exactly one cycle.
- Up with wrap: bank at 0xE, op 01, data 3. q goes 0xF, 0x0, 0x1 on successive edges; busy is high for 3 cycles, then done pulses.
- Down with wrap, then zero-step commands:
  - Bank at 0x1, op 10, data 2: q goes 0x0, 0xF. The toggle mask in the second cycle is 0xF.
  - Next, op 01 with data 0: done asserts the cycle after acceptance, busy never asserts, and q stays 0xF.
- Clear, and busy rejection: bank at 0x7, op 11 gives q=0x0 after one edge. A cmd_valid held during RUN and DONE is not accepted until cmd_ready=1 in IDLE.
- Reset mid-run: op 01, data 10 from 0x0, with clr asserted after 4 steps.
  - q=0x4 at the moment clr asserts.
  - Immediately after clr: j=k=0, busy=0, no done pulse.
  - A new command is accepted normally after release.
